// File: rtl/cdt_link_pkg.sv
// Shared definitions for the CDT serial link: word width, default sync
// pattern and the aligner's two-state FSM encoding.
package cdt_link_pkg;

   localparam int WORD_W = 16;

   // Default frame sync pattern, MSB received first.
   localparam logic [WORD_W-1:0] SYNC_WORD_DEF = 16'hAAAA;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

endpackage

// File: rtl/serial_word_aligner.sv
// serial_word_aligner
//   Deserialises the 1-bit CDT link into 16-bit words whose boundary is locked
//   to SYNC_WORD. Hunts bit by bit for the sync pattern, then emits one word
//   every 16 valid bits and re-checks sync at every frame start. MISS_MAX
//   consecutive frame-start misses drop it back to hunting.
//
// Ports
//   clk      in   1   system clock, rising edge
//   rst      in   1   asynchronous active-low reset
//   sin      in   1   serial data, MSB of each word first
//   sin_vld  in   1   sin valid this cycle (invalid cycles are ignored)
//   out      out  16  aligned word, held between updates
//   out_vld  out  1   one-cycle strobe, out updated
//   locked   out  1   high while in LOCKED
//   sof      out  1   with out_vld: out is a matching frame-start sync word
//   err_cnt  out  8   saturating sync-miss count
//
// Configuration
//   SYNC_ERR_CNT_EN  defined: err_cnt counts frame-start sync misses
//                    (saturating at 8'hFF, cleared only by reset).
//                    undefined: err_cnt tied to zero.
module serial_word_aligner
   import cdt_link_pkg::*;
#(
   parameter logic [WORD_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
   parameter int                FRAME_LEN = 19,
   parameter int                MISS_MAX  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sin,
   input  logic              sin_vld,
   output logic [WORD_W-1:0] out,
   output logic              out_vld,
   output logic              locked,
   output logic              sof,
   output logic [7:0]        err_cnt
);

   localparam int IDX_W = $clog2(FRAME_LEN);

   state_t            state;
   logic [WORD_W-1:0] sr;
   logic [WORD_W-1:0] sr_next;
   logic [3:0]        bit_cnt;
   logic [IDX_W-1:0]  word_idx;
   logic [2:0]        miss_cnt;
   logic              sync_hit;
   logic              frame_start;

   // All comparisons look at the register value including this cycle's bit.
   assign sr_next     = {sr[WORD_W-2:0], sin};
   assign sync_hit    = (sr_next == SYNC_WORD);
   assign frame_start = (word_idx == '0);
   assign locked      = (state == LOCKED);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= HUNT;
         sr       <= '0;
         bit_cnt  <= '0;
         word_idx <= '0;
         miss_cnt <= '0;
         out      <= '0;
         out_vld  <= 1'b0;
         sof      <= 1'b0;
      end else begin
         out_vld <= 1'b0;
         sof     <= 1'b0;
         if (sin_vld) begin
            sr <= sr_next;
            if (state == HUNT) begin
               // First full match wins; the link idles at 0 before a frame, so
               // the 2-bit self-similarity of the pattern cannot lock early.
               if (sync_hit) begin
                  out      <= sr_next;
                  out_vld  <= 1'b1;
                  sof      <= 1'b1;
                  bit_cnt  <= '0;
                  word_idx <= IDX_W'(1);
                  miss_cnt <= '0;
                  state    <= LOCKED;
               end
            end else if (bit_cnt == 4'd15) begin
               out      <= sr_next;
               out_vld  <= 1'b1;
               bit_cnt  <= '0;
               word_idx <= (word_idx == IDX_W'(FRAME_LEN - 1)) ? '0 : word_idx + IDX_W'(1);
               // Only the frame-start word is checked; payload equal to the
               // sync pattern is ordinary data.
               if (frame_start) begin
                  if (sync_hit) begin
                     sof      <= 1'b1;
                     miss_cnt <= '0;
                  end else begin
                     miss_cnt <= miss_cnt + 3'd1;
                     if (miss_cnt == 3'(MISS_MAX - 1))
                        state <= HUNT;
                  end
               end
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
            end
         end
      end
   end

`ifdef SYNC_ERR_CNT_EN
   logic       miss;
   logic [7:0] err_q;

   assign miss = sin_vld && (state == LOCKED) && (bit_cnt == 4'd15) && frame_start && !sync_hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         err_q <= '0;
      else if (miss && (err_q != 8'hFF))
         err_q <= err_q + 8'd1;
   end

   assign err_cnt = err_q;
`else
   assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_serial_word_aligner.sv
// Testbench for serial_word_aligner: directed frame scenarios with random
// payloads, random valid gaps and random data on invalid cycles. Expected
// strobes come from a bit-stream reference model that scans the accepted bits
// for sync windows and slices words at fixed 16-bit offsets.
module tb_serial_word_aligner;

   localparam logic [15:0] SYNC      = 16'hAAAA;
   localparam int          FRAME_LEN = 19;
   localparam int          MISS_MAX  = 3;

   typedef struct {
      logic [15:0] w;
      logic        sof;
      int          cyc;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sin = 1'b0;
   logic        sin_vld = 1'b0;
   logic [15:0] out;
   logic        out_vld;
   logic        locked;
   logic        sof;
   logic [7:0]  err_cnt;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   vb[$];
   int   ve[$];
   ev_t  exp_q[$];
   ev_t  got_q[$];

   serial_word_aligner dut (
      .clk     (clk),
      .rst     (rst),
      .sin     (sin),
      .sin_vld (sin_vld),
      .out     (out),
      .out_vld (out_vld),
      .locked  (locked),
      .sof     (sof),
      .err_cnt (err_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk)
      if (rst && out_vld) got_q.push_back('{w: out, sof: sof, cyc: cyc});

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Reference model: words are 16-bit windows of the accepted bit stream.
   // Hunting tries every window; once locked, windows step by 16 and every
   // FRAME_LEN-th window must equal the sync pattern.
   task automatic run_model(output bit lk, output int errs);
      int j, widx, miss;
      bit hunting;
      logic [15:0] w;
      exp_q.delete();
      hunting = 1; errs = 0; miss = 0; widx = 0; j = 15;
      while (j < vb.size()) begin
         w = '0;
         for (int b = j - 15; b <= j; b++) w = {w[14:0], vb[b]};
         if (hunting) begin
            if (w == SYNC) begin
               exp_q.push_back('{w: w, sof: 1'b1, cyc: ve[j] + 1});
               hunting = 0; widx = 0; miss = 0;
               j += 16;
            end else begin
               j++;
            end
         end else begin
            widx = (widx + 1) % FRAME_LEN;
            exp_q.push_back('{w: w, sof: (widx == 0 && w == SYNC), cyc: ve[j] + 1});
            if (widx == 0 && w != SYNC) begin
               miss++; errs++;
               if (miss == MISS_MAX) hunting = 1;
            end else if (widx == 0) begin
               miss = 0;
            end
            j += hunting ? 1 : 16;
         end
      end
      lk = !hunting;
      if (errs > 255) errs = 255;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         sin = 1'($urandom); sin_vld = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   // mode 0: continuous, 1: alternate valid/invalid, 2: random gaps
   task automatic send_bit(input bit b, input int mode);
      if (mode == 2) idle($urandom_range(0, 2));
      sin = b; sin_vld = 1'b1;
      vb.push_back(b); ve.push_back(cyc);
      @(posedge clk); #1;
      if (mode == 1) idle(1);
   endtask

   task automatic send_word(input logic [15:0] w, input int mode);
      for (int i = 15; i >= 0; i--) send_bit(w[i], mode);
   endtask

   task automatic send_zeros(input int n, input int mode);
      for (int i = 0; i < n; i++) send_bit(1'b0, mode);
   endtask

   // kind 0: 1..18, 1: random, 2: 1..18 with word 5 replaced by the sync pattern
   task automatic send_payload(input int kind, input int mode);
      logic [15:0] w;
      for (int p = 1; p <= FRAME_LEN - 1; p++) begin
         w = 16'(p);
         if (kind == 1) w = 16'($urandom);
         if (kind == 2 && p == 5) w = SYNC;
         send_word(w, mode);
      end
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b0; sin_vld = 1'b0;
      #1;
      chk({tag, " rst out"}, 32'(out), 32'h0);
      chk({tag, " rst out_vld"}, 32'(out_vld), 32'h0);
      chk({tag, " rst locked"}, 32'(locked), 32'h0);
      chk({tag, " rst sof"}, 32'(sof), 32'h0);
      chk({tag, " rst err_cnt"}, 32'(err_cnt), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      got_q.delete(); vb.delete(); ve.delete();
      @(posedge clk); #1;
   endtask

   task automatic check_seg(input string tag, input int tail);
      bit lk;
      int errs, n;
      idle(tail);
      run_model(lk, errs);
      chk({tag, " strobes"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s w%0d out", tag, i), 32'(got_q[i].w), 32'(exp_q[i].w));
         chk($sformatf("%s w%0d sof", tag, i), 32'(got_q[i].sof), 32'(exp_q[i].sof));
         chk($sformatf("%s w%0d cyc", tag, i), 32'(got_q[i].cyc), 32'(exp_q[i].cyc));
      end
      chk({tag, " locked"}, 32'(locked), 32'(lk));
`ifdef SYNC_ERR_CNT_EN
      chk({tag, " err_cnt"}, 32'(err_cnt), 32'(errs));
`else
      chk({tag, " err_cnt"}, 32'(err_cnt), 32'h0);
`endif
   endtask

   initial begin
      // A: idle zeros then one clean frame, back-to-back bits
      do_reset("A");
      send_zeros(40, 0);
      send_word(SYNC, 0); send_payload(0, 0);
      check_seg("A", 4);
      chk("A count", 32'(got_q.size()), 32'd19);

      // B: same stream, valid toggling 1,0,1,0
      do_reset("B");
      send_zeros(40, 1);
      send_word(SYNC, 1); send_payload(0, 1);
      check_seg("B", 4);
      if (got_q.size() > 1) chk("B spacing", 32'(got_q[1].cyc - got_q[0].cyc), 32'd32);

      // C: payload equal to sync pattern, random gaps, random payload frame
      do_reset("C");
      send_zeros(40, 2);
      send_word(SYNC, 2); send_payload(2, 2);
      send_word(SYNC, 2); send_payload(1, 2);
      check_seg("C", 4);
      if (got_q.size() > 5) chk("C payload sync sof", 32'(got_q[5].sof), 32'h0);

      // D: three corrupt sync words drop the lock; clean sync relocks
      do_reset("D");
      send_zeros(40, 0);
      send_word(SYNC, 0); send_payload(1, 0);
      send_word(16'hAAAB, 0); send_payload(0, 0);
      send_word(16'hAAAB, 0); idle(2);
      chk("D locked after 2 misses", 32'(locked), 32'h1);
      send_payload(0, 0);
      send_word(16'hAAAB, 0); idle(2);
      chk("D locked after 3 misses", 32'(locked), 32'h0);
      send_payload(0, 0);
      send_zeros(16, 0);
      send_word(SYNC, 0); send_payload(0, 0);
      check_seg("D", 4);

      // E: single corrupt sync then clean frame keeps the lock
      do_reset("E");
      send_zeros(40, 2);
      send_word(SYNC, 2); send_payload(1, 2);
      send_word(16'hAAAB, 2); send_payload(1, 2);
      send_word(SYNC, 2); send_payload(1, 2);
      check_seg("E", 4);
      chk("E still locked", 32'(locked), 32'h1);

      // F: reset mid-word (bit 7 of payload word 5), then relock
      do_reset("F0");
      send_zeros(40, 0);
      send_word(SYNC, 0);
      for (int p = 1; p <= 4; p++) send_word(16'(p), 0);
      for (int i = 15; i > 8; i--) send_bit(1'(16'd5 >> i), 0);
      check_seg("F0", 0);
      do_reset("F1");
      send_zeros(40, 0);
      send_word(SYNC, 0); send_payload(1, 0);
      check_seg("F1", 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
